// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller: FSM states, cause codes,
// CSR addresses and MSTATUS bit positions.
package trap_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMcause,
        StWMtval,
        StWMstatus,
        StMretW,
        StRedirect
    } trap_state_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;
    localparam logic [3:0] IRQ_MSI       = 4'd3;
    localparam logic [3:0] IRQ_MTI       = 4'd7;
    localparam logic [3:0] IRQ_MEI       = 4'd11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_controller_if.sv
// Bundle of pipeline, CSR-file and fetch-redirect signals around the trap controller.
// master: the controller side; slave: the surrounding core / CSR file.
interface trap_controller_if #(
    parameter int unsigned XLEN = 32
);
    logic            illegal_instr;
    logic            ebreak;
    logic            ecall;
    logic            mret;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_val;
    logic            irq_software;
    logic            irq_timer;
    logic            irq_external;
    logic [XLEN-1:0] mstatus_in;
    logic [XLEN-1:0] mie_in;
    logic [XLEN-1:0] mtvec_in;
    logic [XLEN-1:0] mepc_in;
    logic            csr_write_done;
    logic            csr_write_enable;
    logic [11:0]     csr_write_addr;
    logic [XLEN-1:0] csr_write_data;
    logic            flush;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_busy;

    modport master (
        input  illegal_instr, ebreak, ecall, mret, trap_pc, trap_val,
        input  irq_software, irq_timer, irq_external,
        input  mstatus_in, mie_in, mtvec_in, mepc_in, csr_write_done,
        output csr_write_enable, csr_write_addr, csr_write_data,
        output flush, stall, redirect_valid, redirect_pc, trap_busy
    );

    modport slave (
        output illegal_instr, ebreak, ecall, mret, trap_pc, trap_val,
        output irq_software, irq_timer, irq_external,
        output mstatus_in, mie_in, mtvec_in, mepc_in, csr_write_done,
        input  csr_write_enable, csr_write_addr, csr_write_data,
        input  flush, stall, redirect_valid, redirect_pc, trap_busy
    );
endinterface

// File: rtl/trap_cause_encoder.sv
// Combinational priority encoder: sync exception flags beat enabled interrupts.
// Order: illegal > ebreak > ecall > external > software > timer.
module trap_cause_encoder
    import trap_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_irq_sw,
    input  logic            i_irq_tm,
    input  logic            i_irq_ext,
    input  logic            i_global_ie,
    input  logic            i_mie_sw,
    input  logic            i_mie_tm,
    input  logic            i_mie_ext,
    output logic            o_take,
    output logic [XLEN-1:0] o_cause
);
    logic       w_is_irq;
    logic [3:0] w_code;

    always_comb begin
        o_take   = 1'b1;
        w_is_irq = 1'b0;
        w_code   = 4'd0;
        if (i_illegal) begin
            w_code = CAUSE_ILLEGAL;
        end else if (i_ebreak) begin
            w_code = CAUSE_EBREAK;
        end else if (i_ecall) begin
            w_code = CAUSE_ECALL;
        end else if (i_global_ie && i_mie_ext && i_irq_ext) begin
            w_is_irq = 1'b1;
            w_code   = IRQ_MEI;
        end else if (i_global_ie && i_mie_sw && i_irq_sw) begin
            w_is_irq = 1'b1;
            w_code   = IRQ_MSI;
        end else if (i_global_ie && i_mie_tm && i_irq_tm) begin
            w_is_irq = 1'b1;
            w_code   = IRQ_MTI;
        end else begin
            o_take = 1'b0;
        end
        o_cause = {w_is_irq, {(XLEN-5){1'b0}}, w_code};
    end
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer driving the CSR file's single write port.
// Optional TRAP_VECTORED_EN: interrupts with MTVEC mode 01 jump to base + 4*code.
module trap_controller
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic              clk,
    input logic              rst,
    trap_controller_if.master bus
);
    logic            w_take;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_mret_status;
    logic            w_unused_bits;

    trap_state_t     r_state;
    logic [XLEN-1:0] r_cause, r_tval, r_status, r_target;
    logic            r_we, r_flush, r_stall, r_rv, r_busy;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_data, r_rpc;

    trap_cause_encoder #(.XLEN(XLEN)) u_enc (
        .i_illegal   (bus.illegal_instr),
        .i_ebreak    (bus.ebreak),
        .i_ecall     (bus.ecall),
        .i_irq_sw    (bus.irq_software),
        .i_irq_tm    (bus.irq_timer),
        .i_irq_ext   (bus.irq_external),
        .i_global_ie (bus.mstatus_in[MSTATUS_MIE]),
        .i_mie_sw    (bus.mie_in[IRQ_MSI]),
        .i_mie_tm    (bus.mie_in[IRQ_MTI]),
        .i_mie_ext   (bus.mie_in[IRQ_MEI]),
        .o_take      (w_take),
        .o_cause     (w_cause)
    );

    assign w_unused_bits = ^{bus.mie_in, bus.mtvec_in[1:0]};

    always_comb begin
        w_target = {bus.mtvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (w_cause[XLEN-1] && (bus.mtvec_in[1:0] == 2'b01)) begin
            w_target = w_target + {{(XLEN-6){1'b0}}, w_cause[3:0], 2'b00};
        end
`endif
        w_trap_status                                = bus.mstatus_in;
        w_trap_status[MSTATUS_MPIE]                  = bus.mstatus_in[MSTATUS_MIE];
        w_trap_status[MSTATUS_MIE]                   = 1'b0;
        w_trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        w_mret_status                                = bus.mstatus_in;
        w_mret_status[MSTATUS_MIE]                   = bus.mstatus_in[MSTATUS_MPIE];
        w_mret_status[MSTATUS_MPIE]                  = 1'b1;
        w_mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cause  <= '0;
            r_tval   <= '0;
            r_status <= '0;
            r_target <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_flush  <= 1'b0;
            r_stall  <= 1'b0;
            r_rv     <= 1'b0;
            r_rpc    <= RESET_VECTOR;
            r_busy   <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_rv    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_rpc <= RESET_VECTOR;
                    // A trap and an MRET in the same cycle: the trap wins, the MRET is dropped.
                    if (w_take) begin
                        r_state  <= StWMepc;
                        r_cause  <= w_cause;
                        r_tval   <= bus.trap_val;
                        r_status <= w_trap_status;
                        r_target <= w_target;
                        r_we     <= 1'b1;
                        r_addr   <= CSR_MEPC;
                        r_data   <= bus.trap_pc;
                        r_flush  <= 1'b1;
                        r_stall  <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (bus.mret) begin
                        r_state  <= StMretW;
                        r_target <= bus.mepc_in;
                        r_we     <= 1'b1;
                        r_addr   <= CSR_MSTATUS;
                        r_data   <= w_mret_status;
                        r_flush  <= 1'b1;
                        r_stall  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                StWMepc: if (bus.csr_write_done) begin
                    r_state <= StWMcause;
                    r_addr  <= CSR_MCAUSE;
                    r_data  <= r_cause;
                end
                StWMcause: if (bus.csr_write_done) begin
                    r_state <= StWMtval;
                    r_addr  <= CSR_MTVAL;
                    r_data  <= r_tval;
                end
                StWMtval: if (bus.csr_write_done) begin
                    r_state <= StWMstatus;
                    r_addr  <= CSR_MSTATUS;
                    r_data  <= r_status;
                end
                StWMstatus, StMretW: if (bus.csr_write_done) begin
                    r_state <= StRedirect;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_data  <= '0;
                    r_rv    <= 1'b1;
                    r_rpc   <= r_target;
                end
                StRedirect: begin
                    r_state <= StIdle;
                    r_stall <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rpc   <= RESET_VECTOR;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.csr_write_enable = r_we;
    assign bus.csr_write_addr   = r_addr;
    assign bus.csr_write_data   = r_data;
    assign bus.flush            = r_flush;
    assign bus.stall            = r_stall;
    assign bus.redirect_valid   = r_rv;
    assign bus.redirect_pc      = r_rpc;
    assign bus.trap_busy        = r_busy;
endmodule
